// File: rtl/spi_dso_pkg.sv
// spi_dso_pkg: DSO SPI peripheral map, device ID and host FSM states shared by the SPI host and its benches.
package spi_dso_pkg;
  localparam logic [7:0] DSO_DEVICE_ID = 8'h91;
  localparam logic [7:0] WRITE_FLAG    = 8'h80;
  localparam logic [2:0] ADC_CFG   = 3'd0;
  localparam logic [2:0] ADC_BUF   = 3'd1;
  localparam logic [2:0] DDS_A_CFG = 3'd2;
  localparam logic [2:0] DDS_B_CFG = 3'd3;
  localparam logic [2:0] DDS_A_TBL = 3'd4;
  localparam logic [2:0] DDS_B_TBL = 3'd5;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP} state_t;
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: SCK half-period counter; rise/fall/sample strobe the last clk cycle before SCK toggles.
module spi_sck_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cnt_en,
  input  logic tog_en,
  output logic sck_spi,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sample
);
  logic [7:0] cnt;
  assign tick   = cnt_en && cnt == 8'(CLK_DIV - 1);
  assign rise   = tick && tog_en && !sck_spi;
  assign fall   = tick && tog_en && sck_spi;
  assign sample = fall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      sck_spi <= 1'b0;
    end else begin
      cnt     <= cnt_en && !tick ? cnt + 8'd1 : '0;
      sck_spi <= sck_spi ^ (tick && tog_en);
    end
  end
endmodule

// File: rtl/spi_host_master.sv
// spi_host_master: SPI mode-0 initiator for one DSO session (command byte, then len payload bytes).
// Define SPI_HOST_ID_CHECK_EN to add the id_error port and the device-ID comparator.
module spi_host_master
  import spi_dso_pkg::*;
#(
  parameter int CLK_DIV  = 8,
  parameter int IDLE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [7:0]  dev_id,
`ifdef SPI_HOST_ID_CHECK_EN
  output logic        id_error,
`endif
  output logic        ncs_spi,
  output logic        sck_spi,
  output logic        mosi_spi,
  input  logic        miso_spi
);
  localparam int GW = $clog2(IDLE_CYC + 1);
  state_t s, s_nxt;
  logic [7:0] tx_sr, rx_sr, rx_byte;
  logic [2:0] bit_cnt;
  logic [15:0] byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic is_cmd, tick, rise, fall, sample, accept, byte_end;
  assign accept   = s == IDLE && start;
  assign byte_end = fall && bit_cnt == 3'd7;
  assign rx_byte  = {rx_sr[6:0], miso_spi};
  assign mosi_spi = tx_sr[7];
  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt_en (s inside {CS_SETUP, SHIFT, CS_HOLD}),
    .tog_en (s inside {CS_SETUP, SHIFT}),
    .sck_spi(sck_spi),
    .tick   (tick),
    .rise   (rise),
    .fall   (fall),
    .sample (sample)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= IDLE;
    else s <= s_nxt;
  end
  always_comb begin
    s_nxt = s;
    case (s)
      IDLE:     s_nxt = start ? CS_SETUP : IDLE;
      CS_SETUP: s_nxt = rise ? SHIFT : CS_SETUP;
      SHIFT:    s_nxt = byte_end && byte_cnt == '0 ? CS_HOLD : SHIFT;
      CS_HOLD:  s_nxt = tick ? CS_GAP : CS_HOLD;
      CS_GAP:   s_nxt = gap_cnt == GW'(IDLE_CYC - 1) ? IDLE : CS_GAP;
      default:  s_nxt = IDLE;
    endcase
  end
  // The final falling edge of a byte either loads the next payload byte or ends the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_spi  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      dev_id   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      is_cmd   <= 1'b0;
    end else begin
      ncs_spi  <= s_nxt == IDLE || s_nxt == CS_GAP;
      busy     <= s_nxt != IDLE;
      done     <= s == CS_GAP && s_nxt == IDLE;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      gap_cnt  <= s == CS_GAP ? gap_cnt + GW'(1) : '0;
      if (accept) begin
        tx_sr    <= cmd;
        byte_cnt <= len;
        bit_cnt  <= '0;
        is_cmd   <= 1'b1;
      end
      if (sample) rx_sr <= rx_byte;
      if (fall) begin
        bit_cnt <= bit_cnt + 3'd1;
        tx_sr   <= {tx_sr[6:0], 1'b0};
      end
      if (byte_end && byte_cnt != '0) begin
        tx_sr    <= tx_data;
        byte_cnt <= byte_cnt - 16'd1;
        tx_ready <= 1'b1;
      end
      if (byte_end) begin
        is_cmd <= 1'b0;
        if (is_cmd) dev_id <= rx_byte;
        else begin
          rx_data  <= rx_byte;
          rx_valid <= 1'b1;
        end
      end
    end
  end
`ifdef SPI_HOST_ID_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_error <= 1'b0;
    else if (accept) id_error <= 1'b0;
    else if (byte_end && is_cmd && rx_byte != DSO_DEVICE_ID) id_error <= 1'b1;
  end
`endif
endmodule

// File: doc/spi_host_master.md
# spi_host_master

SPI initiator that drives one complete DSO SPI session: a command byte (write flag in bit 7, peripheral address in bits 2:0) followed by a programmable number of payload bytes. The block runs in SPI mode 0, MSB first. During the command byte it captures the device ID/version byte returned by the responder. It sits in the board-test and bridge designs, where FPGA logic stands in for the MCU and talks to the DSO's SPI peripheral set (ADC config, ADC buffer/status, DDS config, DDS tables).

## Interface
- CLK_DIV, 8: SCK half-period in clk cycles; legal range 4..255.
- IDLE_CYC, 16: minimum clk cycles ncs_spi stays high between sessions; must be ≥1.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  session request; accepted only when busy=0.
- cmd  in  8  command byte; latched on start.
- len  in  16  payload byte count; latched on start; 0 is legal.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- tx_data  in  8  next payload byte to send.
- tx_ready  out  1  one-cycle pulse when tx_data is latched.
- rx_data  out  8  last received payload byte.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- dev_id  out  8  byte received during the command byte.
- id_error  out  1  ID mismatch flag; present only with SPI_HOST_ID_CHECK_EN.
- ncs_spi  out  1  chip select, active-low.
- sck_spi  out  1  SPI clock; idles low.
- mosi_spi  out  1  serial data out.
- miso_spi  in  1  serial data in.

## Operation
- States: IDLE → CS_SETUP → SHIFT → CS_HOLD → CS_GAP → IDLE.
- **IDLE:** ncs_spi=1, sck_spi=0. When start=1, latch cmd and len, set busy=1, and go to CS_SETUP.
- **CS_SETUP:** ncs_spi=0 and mosi_spi=cmd[7]; lasts CLK_DIV cycles.
- **SHIFT:** each bit is a high phase followed by a low phase, each CLK_DIV cycles.
  - miso_spi is sampled in the last clk cycle of the high phase. This tolerates the responder's SCK synchronizer latency.
  - mosi_spi advances on the falling edge.
  - The low phase of the final bit is replaced by CS_HOLD.
- **Payload loading:** each payload byte is loaded from tx_data on the falling edge that ends the previous byte; tx_ready pulses in that same cycle. Upstream must hold the next byte stable before the next load.
- **Byte completion:**
  - After the command byte, the received byte is written to dev_id.
  - After each payload byte, the received byte is written to rx_data, and rx_valid pulses the following cycle.
- **Session length:** total bits = 8·(1+len).
- **CS_HOLD:** sck_spi=0 for CLK_DIV cycles, then ncs_spi=1.
- **CS_GAP:** lasts IDLE_CYC cycles. On exit, done pulses, busy=0 in the same cycle, and the state returns to IDLE.
- **Boundary behaviour:**
  - start while busy=1: ignored.
  - len=0: command byte only; no tx_ready and no rx_valid pulses.
  - len=65535: no wrap; the byte counter is 16 bits, counting down.
  - rst_n low mid-session: ncs_spi=1 immediately (asynchronously); no done pulse.

## Timing
- Reset values: busy=0, done=0, tx_ready=0, rx_valid=0, rx_data=0x00, dev_id=0x00, id_error=0, ncs_spi=1, sck_spi=0, mosi_spi=0.
- All outputs are registered.
- Latency from start to ncs_spi falling: 1 cycle.
- ncs_spi low duration: (16·(1+len)+1)·CLK_DIV cycles.
- Latency from ncs_spi rising to done: IDLE_CYC cycles.
- Back-to-back sessions: start asserted in the same cycle as done is accepted in the next cycle.

## Configuration
- SPI_HOST_ID_CHECK_EN defined:
  - After the command byte, dev_id is compared with DSO_DEVICE_ID (0x91).
  - On mismatch, id_error is set and held until the next accepted start.
  - The session always completes; it is not aborted.
- SPI_HOST_ID_CHECK_EN undefined: the id_error port and the comparator are absent.

## Structure
- Shared package spi_dso_pkg holds:
  - DSO_DEVICE_ID = 8'h91.
  - Address constants: ADC_CFG=0, ADC_BUF=1, DDS_A_CFG=2, DDS_B_CFG=3, DDS_A_TBL=4, DDS_B_TBL=5.
  - WRITE_FLAG = 8'h80.
  - The state enum.
- Sub-module spi_sck_gen: half-period counter producing rise/fall/sample strobes and driving sck_spi. The FSM, shift registers and byte counter live in the top module.

## Test plan
- **Write session:** CLK_DIV=4; cmd=0x82, len=4, tx bytes 11 22 33 44. Expected:
  - mosi_spi shows 82 11 22 33 44 MSB-first.
  - 40 sck_spi rising edges.
  - ncs_spi low for exactly 324 cycles.
  - 4 tx_ready pulses and one done pulse.
- **Status read:** cmd=0x01, len=2; responder model returns 0x91, 0x5A, 0x12. Expected: dev_id=0x91; rx_valid pulses twice with rx_data 0x5A then 0x12.
- **Empty payload:** len=0. Expected: 8 rising edges; no tx_ready and no rx_valid pulses; done pulses.
- **Start handling:**
  - start pulsed mid-session: no effect.
  - start held high continuously: ncs_spi high for ≥IDLE_CYC cycles between the two sessions.
- **Reset mid-session:** rst_n low during the 3rd payload bit. Expected: ncs_spi=1, sck_spi=0, busy=0 before the next clk edge; no done pulse.
- **ID check:** with SPI_HOST_ID_CHECK_EN, responder returns 0x00 in the command byte. Expected:
  - id_error=1 and the session still completes.
  - id_error clears on the next accepted start.
